// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start-bit qualification, LSB-first deserialisation,
// optional parity, 1-2 stop bits, valid/ready holding register with overrun flag.
module uart_rx_core #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              sample_tick,
    input  logic              rx_i,
    input  logic [1:0]        parity_mode_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  samp_cnt;
    logic [3:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_en;
    logic              par_odd;
    logic              par_err;
    logic              frm_err;
    logic              done;
    logic              rx_meta;
    logic              rx_s;
    logic              rx_prev;
    logic              half_point;
    logic              bit_point;
    logic              accept;

    // rx_prev lets IDLE demand a real falling edge, so a held-low break line
    // cannot retrigger a new frame until it has gone high again.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign half_point = sample_tick && (samp_cnt == HALF_LAST);
    assign bit_point  = sample_tick && (samp_cnt == BIT_LAST);
    assign accept     = valid_o && ready_i;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            samp_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_en   <= 1'b0;
            par_odd  <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            done     <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    samp_cnt <= '0;
                    if (rx_prev && !rx_s) begin
                        state  <= START;
                        busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (half_point) begin
                        samp_cnt <= '0;
                        bit_cnt  <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            par_en  <= (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
                            par_odd <= (parity_mode_i == 2'b10);
                            par_err <= 1'b0;
                            frm_err <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end else if (sample_tick) begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_point) begin
                        samp_cnt <= '0;
                        shreg    <= {rx_s, shreg[DATA_W-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= par_en ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sample_tick) begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_point) begin
                        samp_cnt <= '0;
                        par_err  <= (^shreg) ^ rx_s ^ par_odd;
                        state    <= STOP;
                    end else if (sample_tick) begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so the next start edge is never missed.
                    if (bit_point) begin
                        samp_cnt <= '0;
                        if (!rx_s) begin
                            frm_err <= 1'b1;
                        end
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                            busy_o  <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sample_tick) begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // A frame finishing while the held word is still unaccepted is dropped.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else if (done) begin
            if (valid_o && !ready_i) begin
                overrun_o <= 1'b1;
            end else begin
                data_o       <= shreg;
                parity_err_o <= par_err;
                frame_err_o  <= frm_err;
                valid_o      <= 1'b1;
                if (accept) begin
                    overrun_o <= 1'b0;
                end
            end
        end else if (accept) begin
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: an 8-bit/16x/1-stop instance and a
// 9-bit/8x/2-stop instance, directed scenarios followed by random frames.
module tb_uart_rx_core;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    typedef logic bitq_t[$];

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       sample_tick = 1'b1;
    logic       rx_line [2];
    logic [1:0] mode_in [2];
    logic       ready_force [2];
    logic       ready_rnd [2];
    logic       rand_en [2];
    logic       ready_in [2];
    logic [7:0] data0;
    logic [8:0] data1;
    logic       valid_s [2];
    logic       perr_s [2];
    logic       ferr_s [2];
    logic       ovr_s [2];
    logic       busy_s [2];

    exp_t       exp_q0[$];
    exp_t       exp_q1[$];
    logic       hold_prev [2];
    logic [10:0] held [2];
    int         checks = 0;
    int         failures = 0;

    assign ready_in[0] = rand_en[0] ? ready_rnd[0] : ready_force[0];
    assign ready_in[1] = rand_en[1] ? ready_rnd[1] : ready_force[1];

    uart_rx_core #(.DATA_W(8), .OVERSAMPLE(16), .STOP_BITS(1)) dut0 (
        .clk(clk), .nrst(nrst), .sample_tick(sample_tick), .rx_i(rx_line[0]),
        .parity_mode_i(mode_in[0]), .data_o(data0), .valid_o(valid_s[0]),
        .ready_i(ready_in[0]), .parity_err_o(perr_s[0]), .frame_err_o(ferr_s[0]),
        .overrun_o(ovr_s[0]), .busy_o(busy_s[0])
    );

    uart_rx_core #(.DATA_W(9), .OVERSAMPLE(8), .STOP_BITS(2)) dut1 (
        .clk(clk), .nrst(nrst), .sample_tick(sample_tick), .rx_i(rx_line[1]),
        .parity_mode_i(mode_in[1]), .data_o(data1), .valid_o(valid_s[1]),
        .ready_i(ready_in[1]), .parity_err_o(perr_s[1]), .frame_err_o(ferr_s[1]),
        .overrun_o(ovr_s[1]), .busy_o(busy_s[1])
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int os_of(input int d);
        return (d == 0) ? 16 : 8;
    endfunction

    function automatic int dw_of(input int d);
        return (d == 0) ? 8 : 9;
    endfunction

    function automatic int sb_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic logic [8:0] data_of(input int d);
        return (d == 0) ? {1'b0, data0} : data1;
    endfunction

    // Expected word from frame contents: parity counts ones, any low stop is a framing error.
    function automatic exp_t model(input int d, input logic [8:0] w, input logic [1:0] mode,
                                   input logic pbit, input logic [1:0] stops);
        exp_t e;
        int   ones;
        ones   = $countones(w);
        e.data = w;
        e.perr = (mode == 2'd1) ? ((ones + int'(pbit)) % 2 == 1) :
                 (mode == 2'd2) ? ((ones + int'(pbit)) % 2 == 0) : 1'b0;
        e.ferr = !stops[0] || (sb_of(d) == 2 && !stops[1]);
        e.ovr  = 1'b0;
        return e;
    endfunction

    function automatic bitq_t build_bits(input int d, input logic [8:0] w, input logic [1:0] mode,
                                         input logic pbit, input logic [1:0] stops);
        bitq_t q;
        q.push_back(1'b0);
        for (int i = 0; i < dw_of(d); i++) q.push_back(w[i]);
        if (mode == 2'd1 || mode == 2'd2) q.push_back(pbit);
        q.push_back(stops[0]);
        if (sb_of(d) == 2) q.push_back(stops[1]);
        return q;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int d, input exp_t e);
        if (d == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    task automatic monitor_step(input int d);
        exp_t       e;
        logic [8:0] dat;
        int         qs;
        dat = data_of(d);
        qs  = (d == 0) ? exp_q0.size() : exp_q1.size();
        if (!nrst) begin
            hold_prev[d] = 1'b0;
            return;
        end
        if (hold_prev[d] && valid_s[d])
            check_output($sformatf("held_word_stable%0d", d), {dat, perr_s[d], ferr_s[d]}, held[d]);
        if (valid_s[d] && ready_in[d]) begin
            if (qs == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_word%0d actual=0x%0h required=none", d, dat);
            end else begin
                e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check_output($sformatf("data%0d", d), dat, e.data);
                check_output($sformatf("parity_err%0d", d), perr_s[d], e.perr);
                check_output($sformatf("frame_err%0d", d), ferr_s[d], e.ferr);
                check_output($sformatf("overrun%0d", d), ovr_s[d], e.ovr);
            end
        end
        hold_prev[d] = valid_s[d] && !ready_in[d];
        held[d]      = {dat, perr_s[d], ferr_s[d]};
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) monitor_step(d);
    end

    always @(posedge clk) begin
        #2;
        ready_rnd[0] = ($urandom_range(0, 3) != 0);
        ready_rnd[1] = ($urandom_range(0, 3) != 0);
    end

    task automatic drive_bits(input int d, input bitq_t q, input int n);
        for (int i = 0; i < n; i++) begin
            rx_line[d] = q[i];
            repeat (os_of(d)) @(posedge clk);
            #1;
            if (i == 0) mode_in[d] = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic apply_stimulus(input int d, input logic [8:0] w, input logic [1:0] mode,
                                  input logic pbit, input logic [1:0] stops, input bit push,
                                  input logic exp_ovr, input int gap);
        bitq_t q;
        exp_t  e;
        @(posedge clk);
        #1;
        mode_in[d] = mode;
        q = build_bits(d, w, mode, pbit, stops);
        if (push) begin
            e     = model(d, w, mode, pbit, stops);
            e.ovr = exp_ovr;
            push_exp(d, e);
        end
        drive_bits(d, q, q.size());
        rx_line[d] = 1'b1;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input int d, input logic level, input int limit, input string name);
        int n = 0;
        while (busy_s[d] !== level && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output(name, busy_s[d], level);
    endtask

    task automatic wait_valid(input int d, input int limit, input string name);
        int n = 0;
        while (valid_s[d] !== 1'b1 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output(name, valid_s[d], 1'b1);
    endtask

    task automatic wait_drain(input int limit, input string name);
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output(name, exp_q0.size() + exp_q1.size(), 0);
    endtask

    task automatic random_frames(input int d, input int n);
        logic [8:0] w;
        logic [1:0] mode;
        logic [1:0] stops;
        logic       pbit;
        logic       last;
        int         gap;
        for (int i = 0; i < n; i++) begin
            w = 9'($urandom);
            if (dw_of(d) == 8) w[8] = 1'b0;
            mode  = 2'($urandom_range(0, 3));
            pbit  = 1'($urandom_range(0, 1));
            stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            last  = (sb_of(d) == 2) ? stops[1] : stops[0];
            gap   = last ? $urandom_range(0, os_of(d)) : os_of(d) + $urandom_range(0, os_of(d));
            apply_stimulus(d, w, mode, pbit, stops, 1'b1, 1'b0, gap);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_output($sformatf("%s_data%0d", tag, d), data_of(d), 0);
            check_output($sformatf("%s_valid%0d", tag, d), valid_s[d], 0);
            check_output($sformatf("%s_perr%0d", tag, d), perr_s[d], 0);
            check_output($sformatf("%s_ferr%0d", tag, d), ferr_s[d], 0);
            check_output($sformatf("%s_ovr%0d", tag, d), ovr_s[d], 0);
            check_output($sformatf("%s_busy%0d", tag, d), busy_s[d], 0);
        end
    endtask

    initial begin
        bitq_t q;
        rx_line     = '{1'b1, 1'b1};
        mode_in     = '{2'd0, 2'd0};
        ready_force = '{1'b1, 1'b1};
        ready_rnd   = '{1'b1, 1'b1};
        rand_en     = '{1'b0, 1'b0};
        hold_prev   = '{1'b0, 1'b0};
        held        = '{11'd0, 11'd0};
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        nrst = 1'b1;
        repeat (5) @(posedge clk);

        $display("[TB] even parity word, one-cycle handshake");
        fork
            apply_stimulus(0, 9'h0A5, 2'd1, 1'b0, 2'b11, 1'b1, 1'b0, 4);
            begin
                wait_valid(0, 400, "a5_valid_rise");
                @(posedge clk);
                #1;
                check_output("a5_valid_cleared", valid_s[0], 1'b0);
            end
        join

        $display("[TB] odd parity and no-parity words");
        apply_stimulus(0, 9'h0A5, 2'd2, 1'b0, 2'b11, 1'b1, 1'b0, 4);
        apply_stimulus(0, 9'h0A5, 2'd2, 1'b1, 2'b11, 1'b1, 1'b0, 4);
        apply_stimulus(0, 9'h03C, 2'd0, 1'b0, 2'b11, 1'b1, 1'b0, 4);
        wait_drain(200, "drain_parity");

        $display("[TB] short start glitch");
        rx_line[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_line[0] = 1'b1;
        wait_busy(0, 1'b1, 10, "glitch_busy_high");
        wait_busy(0, 1'b0, 40, "glitch_busy_low");
        repeat (20) @(posedge clk);
        #1;
        check_output("glitch_no_valid", valid_s[0], 1'b0);

        $display("[TB] two stop bits, break, 9-bit word");
        apply_stimulus(1, 9'h05A, 2'd0, 1'b0, 2'b01, 1'b1, 1'b0, 16);
        push_exp(1, '{data: 9'h000, perr: 1'b0, ferr: 1'b1, ovr: 1'b0});
        mode_in[1] = 2'd0;
        rx_line[1] = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        rx_line[1] = 1'b1;
        repeat (30) @(posedge clk);
        apply_stimulus(1, 9'h1FF, 2'd1, 1'b1, 2'b11, 1'b1, 1'b0, 8);
        wait_drain(200, "drain_dut1");

        $display("[TB] overrun");
        ready_force[0] = 1'b0;
        apply_stimulus(0, 9'h011, 2'd0, 1'b0, 2'b11, 1'b1, 1'b1, 5);
        apply_stimulus(0, 9'h022, 2'd0, 1'b0, 2'b11, 1'b0, 1'b0, 20);
        check_output("ovr_held_data", data0, 8'h11);
        check_output("ovr_held_valid", valid_s[0], 1'b1);
        check_output("ovr_flag_set", ovr_s[0], 1'b1);
        @(posedge clk);
        #1;
        ready_force[0] = 1'b1;
        @(posedge clk);
        #1;
        check_output("ovr_valid_cleared", valid_s[0], 1'b0);
        check_output("ovr_flag_cleared", ovr_s[0], 1'b0);

        $display("[TB] accept on completion cycle");
        ready_force[0] = 1'b0;
        apply_stimulus(0, 9'h033, 2'd0, 1'b0, 2'b11, 1'b1, 1'b0, 4);
        fork
            apply_stimulus(0, 9'h044, 2'd0, 1'b0, 2'b11, 1'b1, 1'b0, 10);
            begin
                wait_busy(0, 1'b1, 100, "b2b_busy_high");
                wait_busy(0, 1'b0, 400, "b2b_busy_low");
                ready_force[0] = 1'b1;
            end
        join
        check_output("b2b_no_overrun", ovr_s[0], 1'b0);
        wait_drain(100, "drain_b2b");

        $display("[TB] reset mid-frame");
        q = build_bits(0, 9'h077, 2'd0, 1'b0, 2'b11);
        @(posedge clk);
        #1;
        mode_in[0] = 2'd0;
        drive_bits(0, q, 5);
        rx_line[0] = q[5];
        repeat (3) @(posedge clk);
        #1;
        check_output("midframe_busy", busy_s[0], 1'b1);
        nrst = 1'b0;
        #1;
        check_all_zero("midreset");
        rx_line[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (5) @(posedge clk);
        apply_stimulus(0, 9'h012, 2'd0, 1'b0, 2'b11, 1'b1, 1'b0, 8);
        wait_drain(100, "drain_after_reset");

        $display("[TB] random frames");
        rand_en = '{1'b1, 1'b1};
        fork
            random_frames(0, 25);
            random_frames(1, 25);
        join
        repeat (10) @(posedge clk);
        #1;
        rand_en = '{1'b0, 1'b0};
        wait_drain(500, "drain_random");
        check_output("final_overrun0", ovr_s[0], 1'b0);
        check_output("final_overrun1", ovr_s[1], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
